// File: rtl/ctrlunit_mc.sv
// ---------------------------------------------------------------------------
// ctrlunit_mc
//   Multi-cycle control unit of the accumulator CPU. Every instruction is
//   sequenced through FETCH -> DECODE -> EXEC and uses a ready handshake
//   towards RAM. Conditional jumps are resolved internally from the Z/C
//   flags, which are sampled in the EXEC cycle. HLT and illegal opcodes park
//   the core in HALT, which is left only through reset.
//
// Configuration macro:
//   INSTR_CNT_EN : adds the CNT_W parameter, the retired-instruction
//                  counter and the icount_o port. Absent when undefined.
//
// Parameters:
//   OP_W  : opcode width (>= 4); any set bit above bit 3 is an illegal opcode
//   CNT_W : retired-instruction counter width (INSTR_CNT_EN only)
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-high reset
//   run_i        in   start / continue execution
//   op_i         in   opcode from instruction register (sampled in DECODE)
//   zf_i, cf_i   in   zero / carry flags (sampled in EXEC)
//   mem_ready_i  in   memory access completes this cycle
//   mem_rd_o     out  memory read request
//   wm_o         out  memory write request
//   ir_ld_o      out  load instruction register
//   pc_inc_o     out  increment PC
//   jmp_o        out  load PC from operand
//   wr_o         out  write accumulator
//   wf_o         out  write flag register
//   alu_op_o     out  000 ADD, 001 SUB, 010 AND, 011 OR, 100 PASS
//   state_o      out  0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 HALT
//   halt_o       out  core halted
//   illegal_o    out  halted on an illegal opcode
//   icount_o     out  retired instructions, wraps (INSTR_CNT_EN only)
//
// All control outputs decode combinationally from the current state, the
// registered opcode and the handshake/flag inputs; since state resets
// asynchronously, outputs drop as soon as rst_i rises.
// ---------------------------------------------------------------------------
module ctrlunit_mc #(
  parameter int unsigned OP_W  = 4
`ifdef INSTR_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             zf_i,
  input  logic             cf_i,
  input  logic             mem_ready_i,
  output logic             mem_rd_o,
  output logic             wm_o,
  output logic             ir_ld_o,
  output logic             pc_inc_o,
  output logic             jmp_o,
  output logic             wr_o,
  output logic             wf_o,
  output logic [2:0]       alu_op_o,
  output logic [2:0]       state_o,
  output logic             halt_o,
  output logic             illegal_o
`ifdef INSTR_CNT_EN
  ,
  output logic [CNT_W-1:0] icount_o
`endif
);

  localparam int unsigned ST_W  = 3;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned NIB_W = 4;

  // Opcode map (low nibble of the registered opcode)
  localparam logic [NIB_W-1:0] OPC_ADD = 4'd0;
  localparam logic [NIB_W-1:0] OPC_SUB = 4'd1;
  localparam logic [NIB_W-1:0] OPC_LDA = 4'd2;
  localparam logic [NIB_W-1:0] OPC_STA = 4'd3;
  localparam logic [NIB_W-1:0] OPC_JMP = 4'd4;
  localparam logic [NIB_W-1:0] OPC_JZ  = 4'd5;
  localparam logic [NIB_W-1:0] OPC_JC  = 4'd6;
  localparam logic [NIB_W-1:0] OPC_AND = 4'd7;
  localparam logic [NIB_W-1:0] OPC_OR  = 4'd8;
  localparam logic [NIB_W-1:0] OPC_NOP = 4'd9;
  localparam logic [NIB_W-1:0] OPC_HLT = 4'd15;

  // ALU function codes
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR   = 3'b011;
  localparam logic [ALU_W-1:0] ALU_PASS = 3'b100;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q;
  logic             illegal_q;

  logic [NIB_W-1:0] op_lo;
  logic             op_hi_set;
  logic             op_alu, op_lda, op_sta;
  logic             op_jmp, op_jz, op_jc, op_nop, op_hlt, op_bad;
  logic [ALU_W-1:0] alu_sel;
  logic             mem_op;
  logic             retire;

  assign op_lo     = op_q[NIB_W-1:0];
  // Any bit above the base nibble makes the opcode illegal (zero when OP_W == 4)
  assign op_hi_set = (op_q >> NIB_W) != '0;

  // Opcode classification of the registered opcode
  always_comb begin : op_decode
    op_alu  = 1'b0;
    op_lda  = 1'b0;
    op_sta  = 1'b0;
    op_jmp  = 1'b0;
    op_jz   = 1'b0;
    op_jc   = 1'b0;
    op_nop  = 1'b0;
    op_hlt  = 1'b0;
    op_bad  = 1'b0;
    alu_sel = ALU_ADD;
    if (op_hi_set) begin
      op_bad = 1'b1;
    end else begin
      case (op_lo)
        OPC_ADD: begin op_alu = 1'b1; alu_sel = ALU_ADD;  end
        OPC_SUB: begin op_alu = 1'b1; alu_sel = ALU_SUB;  end
        OPC_AND: begin op_alu = 1'b1; alu_sel = ALU_AND;  end
        OPC_OR:  begin op_alu = 1'b1; alu_sel = ALU_OR;   end
        OPC_LDA: begin op_lda = 1'b1; alu_sel = ALU_PASS; end
        OPC_STA: op_sta = 1'b1;
        OPC_JMP: op_jmp = 1'b1;
        OPC_JZ:  op_jz  = 1'b1;
        OPC_JC:  op_jc  = 1'b1;
        OPC_NOP: op_nop = 1'b1;
        OPC_HLT: op_hlt = 1'b1;
        default: op_bad = 1'b1;
      endcase
    end
  end

  assign mem_op = op_alu | op_lda | op_sta;

  // An instruction retires when EXEC finishes normally (HLT / illegal never do)
  assign retire = (state_q == ST_EXEC) &&
                  (mem_op ? mem_ready_i : (op_jmp | op_jz | op_jc | op_nop));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin : state_reg
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run_i) state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready_i) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (op_bad || op_hlt) begin
          state_d = ST_HALT;
        end else if (retire) begin
          // A dropped run_i takes effect only at the next fetch boundary
          state_d = run_i ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin : out_decode
    mem_rd_o  = 1'b0;
    wm_o      = 1'b0;
    ir_ld_o   = 1'b0;
    pc_inc_o  = 1'b0;
    jmp_o     = 1'b0;
    wr_o      = 1'b0;
    wf_o      = 1'b0;
    alu_op_o  = ALU_ADD;
    halt_o    = 1'b0;
    illegal_o = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_rd_o = 1'b1;
        if (mem_ready_i) begin
          ir_ld_o  = 1'b1;
          pc_inc_o = 1'b1;
        end
      end
      ST_EXEC: begin
        if (op_alu || op_lda) begin
          mem_rd_o = 1'b1;
          // Result is committed only in the cycle the operand arrives
          if (mem_ready_i) begin
            wr_o     = 1'b1;
            wf_o     = op_alu;
            alu_op_o = alu_sel;
          end
        end
        if (op_sta) begin
          wm_o = 1'b1;
        end
        jmp_o = op_jmp | (op_jz & zf_i) | (op_jc & cf_i);
      end
      ST_HALT: begin
        halt_o    = 1'b1;
        illegal_o = illegal_q;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

  // Opcode register, loaded in DECODE
  always_ff @(posedge clk_i or posedge rst_i) begin : op_reg
    if (rst_i) begin
      op_q <= '0;
    end else if (state_q == ST_DECODE) begin
      op_q <= op_i;
    end
  end

  // Sticky illegal-opcode flag
  always_ff @(posedge clk_i or posedge rst_i) begin : illegal_reg
    if (rst_i) begin
      illegal_q <= 1'b0;
    end else if ((state_q == ST_EXEC) && op_bad) begin
      illegal_q <= 1'b1;
    end
  end

`ifdef INSTR_CNT_EN
  logic [CNT_W-1:0] icount_q;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk_i or posedge rst_i) begin : icount_reg
    if (rst_i) begin
      icount_q <= '0;
    end else if (retire) begin
      icount_q <= icount_q + CNT_W'(1);
    end
  end

  assign icount_o = icount_q;
`endif

  // Bus-level exclusivity properties
  a_rd_wm_excl: assert property (@(posedge clk_i) disable iff (rst_i)
                                 !(mem_rd_o && wm_o));
  a_jmp_inc_excl: assert property (@(posedge clk_i) disable iff (rst_i)
                                   !(jmp_o && pc_inc_o));

endmodule

// File: tb/tb_ctrlunit_mc.sv
// ---------------------------------------------------------------------------
// tb_ctrlunit_mc
//   Self-checking bench for ctrlunit_mc. Each instruction is expanded into
//   its expected cycle-by-cycle trace (inputs to drive + outputs to expect),
//   built from the instruction semantics: fetch handshake, one decode cycle,
//   and an execute phase whose length and strobes depend on the opcode.
//   Inputs that must not matter in a cycle are randomised.
// ---------------------------------------------------------------------------
module tb_ctrlunit_mc;

  localparam int unsigned OP_W = 4;

  logic            clk_i;
  logic            rst_i;
  logic            run_i;
  logic [OP_W-1:0] op_i;
  logic            zf_i;
  logic            cf_i;
  logic            mem_ready_i;
  logic            mem_rd_o, wm_o, ir_ld_o, pc_inc_o, jmp_o, wr_o, wf_o;
  logic [2:0]      alu_op_o;
  logic [2:0]      state_o;
  logic            halt_o, illegal_o;
`ifdef INSTR_CNT_EN
  localparam int unsigned CNT_W = 2;
  logic [CNT_W-1:0] icount_o;
`endif

  ctrlunit_mc #(
    .OP_W(OP_W)
`ifdef INSTR_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .run_i       (run_i),
    .op_i        (op_i),
    .zf_i        (zf_i),
    .cf_i        (cf_i),
    .mem_ready_i (mem_ready_i),
    .mem_rd_o    (mem_rd_o),
    .wm_o        (wm_o),
    .ir_ld_o     (ir_ld_o),
    .pc_inc_o    (pc_inc_o),
    .jmp_o       (jmp_o),
    .wr_o        (wr_o),
    .wf_o        (wf_o),
    .alu_op_o    (alu_op_o),
    .state_o     (state_o),
    .halt_o      (halt_o),
    .illegal_o   (illegal_o)
`ifdef INSTR_CNT_EN
    ,
    .icount_o    (icount_o)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       mem_rd;
    logic       wm;
    logic       ir_ld;
    logic       pc_inc;
    logic       jmp;
    logic       wr;
    logic       wf;
    logic [2:0] alu;
    logic       halt;
    logic       ill;
  } obs_t;

  typedef struct packed {
    obs_t       o;
    logic       run;
    logic       rdy;
    logic       zf;
    logic       cf;
    logic [3:0] op;
  } cyc_t;

  obs_t obs;
  cyc_t cyc_q[$];
  int   total;
  int   bad;

  assign obs = obs_t'({state_o, mem_rd_o, wm_o, ir_ld_o, pc_inc_o, jmp_o,
                       wr_o, wf_o, alu_op_o, halt_o, illegal_o});

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic cyc_t rand_cyc();
    cyc_t c;
    c     = '0;
    c.run = 1'($urandom);
    c.rdy = 1'($urandom);
    c.zf  = 1'($urandom);
    c.cf  = 1'($urandom);
    c.op  = 4'($urandom);
    return c;
  endfunction

  function automatic obs_t o_st(input logic [2:0] st);
    obs_t o;
    o    = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic [2:0] alu_of(input int op);
    case (op)
      1:       return 3'b001;
      7:       return 3'b010;
      8:       return 3'b011;
      2:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push_idle(input logic run);
    cyc_t c;
    c     = rand_cyc();
    c.run = run;
    c.o   = o_st(3'd0);
    cyc_q.push_back(c);
  endtask

  task automatic push_halt(input logic ill);
    cyc_t c;
    c      = rand_cyc();
    c.o    = o_st(3'd4);
    c.o.halt = 1'b1;
    c.o.ill  = ill;
    cyc_q.push_back(c);
  endtask

  task automatic push_fetch_wait();
    cyc_t c;
    c        = rand_cyc();
    c.run    = 1'b1;
    c.rdy    = 1'b0;
    c.o      = o_st(3'd1);
    c.o.mem_rd = 1'b1;
    cyc_q.push_back(c);
  endtask

  // Expected trace of one instruction: fw/ew = fetch/exec wait cycles,
  // zf_x/cf_x = flags in the EXEC cycle, run_x = run_i when EXEC finishes.
  task automatic gen_instr(input int op, input int fw, input int ew,
                           input logic zf_x, input logic cf_x, input logic run_x);
    cyc_t c;
    for (int i = 0; i <= fw; i++) begin
      c          = rand_cyc();
      c.run      = 1'b1;
      c.rdy      = (i == fw);
      c.o        = o_st(3'd1);
      c.o.mem_rd = 1'b1;
      c.o.ir_ld  = c.rdy;
      c.o.pc_inc = c.rdy;
      cyc_q.push_back(c);
    end
    c    = rand_cyc();
    c.op = 4'(op);
    c.o  = o_st(3'd2);
    cyc_q.push_back(c);
    if (op inside {0, 1, 2, 3, 7, 8}) begin
      for (int i = 0; i <= ew; i++) begin
        c     = rand_cyc();
        c.rdy = (i == ew);
        if (i == ew) c.run = run_x;
        c.o   = o_st(3'd3);
        if (op == 3) c.o.wm = 1'b1;
        else         c.o.mem_rd = 1'b1;
        if ((i == ew) && (op != 3)) begin
          c.o.wr  = 1'b1;
          c.o.wf  = (op != 2);
          c.o.alu = alu_of(op);
        end
        cyc_q.push_back(c);
      end
    end else if (op inside {4, 5, 6, 9}) begin
      c     = rand_cyc();
      c.run = run_x;
      c.zf  = zf_x;
      c.cf  = cf_x;
      c.o   = o_st(3'd3);
      c.o.jmp = (op == 4) || ((op == 5) && zf_x) || ((op == 6) && cf_x);
      cyc_q.push_back(c);
    end else begin
      c   = rand_cyc();
      c.o = o_st(3'd3);
      cyc_q.push_back(c);
    end
  endtask

  task automatic drive_rec(input cyc_t c);
    @(negedge clk_i);
    run_i       = c.run;
    mem_ready_i = c.rdy;
    zf_i        = c.zf;
    cf_i        = c.cf;
    op_i        = OP_W'(c.op);
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    run_i       = 1'b0;
    mem_ready_i = 1'b0;
    zf_i        = 1'b0;
    cf_i        = 1'b0;
    op_i        = '0;
    cyc_q.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    run_i = 1'b1;
    mem_ready_i = 1'b1;
    op_i = OP_W'(2);
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_hold obs=%h exp=%h", obs, 15'h0);
    end
`ifdef INSTR_CNT_EN
    total++;
    if (icount_o !== '0) begin
      bad++;
      $display("FAIL reset_icount got=%0d exp=0", icount_o);
    end
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      mem_ready_i = 1'($urandom);
      #1;
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL idle_norun cyc=%0d obs=%h exp=%h", i, obs, 15'h0);
      end
    end
  endtask

  task automatic test_lda();
    do_reset();
    push_idle(1'b1);
    gen_instr(2, 0, 0, 1'b0, 1'b0, 1'b1);
    push_fetch_wait();
    foreach (cyc_q[i]) begin
      drive_rec(cyc_q[i]);
      total++;
      if (obs !== cyc_q[i].o) begin
        bad++;
        $display("FAIL lda cyc=%0d obs=%h exp=%h", i, obs, cyc_q[i].o);
      end
    end
  endtask

  task automatic test_add_wait();
    do_reset();
    push_idle(1'b1);
    gen_instr(0, 0, 2, 1'b0, 1'b0, 1'b0);
    push_idle(1'b0);
    foreach (cyc_q[i]) begin
      drive_rec(cyc_q[i]);
      total++;
      if (obs !== cyc_q[i].o) begin
        bad++;
        $display("FAIL add_wait cyc=%0d obs=%h exp=%h", i, obs, cyc_q[i].o);
      end
    end
  endtask

  task automatic test_jumps();
    do_reset();
    push_idle(1'b1);
    gen_instr(5, 0, 0, 1'b1, 1'b0, 1'b1);
    gen_instr(5, 1, 0, 1'b0, 1'b1, 1'b1);
    gen_instr(6, 0, 0, 1'b0, 1'b1, 1'b1);
    gen_instr(6, 0, 0, 1'b1, 1'b0, 1'b1);
    gen_instr(4, 2, 0, 1'b0, 1'b0, 1'b1);
    gen_instr(9, 0, 0, 1'b1, 1'b1, 1'b0);
    push_idle(1'b0);
    foreach (cyc_q[i]) begin
      drive_rec(cyc_q[i]);
      total++;
      if (obs !== cyc_q[i].o) begin
        bad++;
        $display("FAIL jumps cyc=%0d obs=%h exp=%h", i, obs, cyc_q[i].o);
      end
    end
  endtask

  task automatic test_sta_stop();
    do_reset();
    push_idle(1'b1);
    gen_instr(3, 0, 1, 1'b0, 1'b0, 1'b0);
    push_idle(1'b0);
    push_idle(1'b0);
    foreach (cyc_q[i]) begin
      drive_rec(cyc_q[i]);
      total++;
      if (obs !== cyc_q[i].o) begin
        bad++;
        $display("FAIL sta_stop cyc=%0d obs=%h exp=%h", i, obs, cyc_q[i].o);
      end
    end
  endtask

  task automatic test_illegal_halt();
    do_reset();
    push_idle(1'b1);
    gen_instr(12, 1, 0, 1'b0, 1'b0, 1'b1);
    repeat (4) push_halt(1'b1);
    foreach (cyc_q[i]) begin
      drive_rec(cyc_q[i]);
      total++;
      if (obs !== cyc_q[i].o) begin
        bad++;
        $display("FAIL illegal cyc=%0d obs=%h exp=%h", i, obs, cyc_q[i].o);
      end
    end
    // Asynchronous reset in the middle of a cycle
    @(negedge clk_i);
    run_i = 1'b1;
    mem_ready_i = 1'b1;
    #3 rst_i = 1'b1;
    #1;
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL halt_async_rst obs=%h exp=%h", obs, 15'h0);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    run_i = 1'b0;
    cyc_q.delete();
    push_idle(1'b1);
    gen_instr(15, 0, 0, 1'b0, 1'b0, 1'b1);
    repeat (3) push_halt(1'b0);
    foreach (cyc_q[i]) begin
      drive_rec(cyc_q[i]);
      total++;
      if (obs !== cyc_q[i].o) begin
        bad++;
        $display("FAIL hlt cyc=%0d obs=%h exp=%h", i, obs, cyc_q[i].o);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_idle(1'b1);
    gen_instr(0, 0, 3, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_rec(cyc_q[i]);
      total++;
      if (obs !== cyc_q[i].o) begin
        bad++;
        $display("FAIL rst_mid_pre cyc=%0d obs=%h exp=%h", i, obs, cyc_q[i].o);
      end
    end
    @(negedge clk_i);
    run_i = 1'b1;
    mem_ready_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL rst_mid_drop obs=%h exp=%h", obs, 15'h0);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    run_i = 1'b0;
    #1;
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL rst_mid_after obs=%h exp=%h", obs, 15'h0);
    end
  endtask

  task automatic test_random();
    int op;
    logic run_x;
    do_reset();
    push_idle(1'b1);
    for (int k = 0; k < 150; k++) begin
      op    = int'($urandom_range(0, 9));
      run_x = ($urandom_range(0, 3) != 0);
      gen_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                1'($urandom), 1'($urandom), run_x);
      if (!run_x) begin
        if ($urandom_range(0, 1) == 1) push_idle(1'b0);
        push_idle(1'b1);
      end
    end
    foreach (cyc_q[i]) begin
      drive_rec(cyc_q[i]);
      total++;
      if (obs !== cyc_q[i].o) begin
        bad++;
        $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, cyc_q[i].o);
      end
    end
  endtask

`ifdef INSTR_CNT_EN
  task automatic test_icount();
    do_reset();
    push_idle(1'b1);
    for (int k = 0; k < 5; k++) begin
      gen_instr(9, int'($urandom_range(0, 1)), 0, 1'b0, 1'b0, (k != 4));
    end
    push_idle(1'b0);
    foreach (cyc_q[i]) begin
      drive_rec(cyc_q[i]);
      total++;
      if (obs !== cyc_q[i].o) begin
        bad++;
        $display("FAIL icount_trace cyc=%0d obs=%h exp=%h", i, obs, cyc_q[i].o);
      end
    end
    total++;
    if (icount_o !== CNT_W'(5 % (1 << CNT_W))) begin
      bad++;
      $display("FAIL icount got=%0d exp=%0d", icount_o, 5 % (1 << CNT_W));
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_lda();
    test_add_wait();
    test_jumps();
    test_sta_stop();
    test_illegal_halt();
    test_reset_mid();
    test_random();
`ifdef INSTR_CNT_EN
    test_icount();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
